dma_reg_responder: RTL and testbench
====================================

# dma_reg_responder

Register-file responder for the DMA control bus: accepts single-cycle register writes and reads from the bus initiator (testbench driver or host) and returns registered read data. Holds the DMA descriptor registers and contains a countdown transfer engine that runs a programmed length, reports busy/done/error status and raises an interrupt. It is the DUT end of the same bus the DMA driver and monitor operate.

## Interface
- DATA_WIDTH, 32, register and bus data width; minimum 32.
- ADDR_WIDTH, 16, byte address width.
- clk  in  1  bus clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; one write per cycle asserted.
- rd_en  in  1  read strobe; one read per cycle asserted.
- wdata  in  DATA_WIDTH  write data.
- addr  in  ADDR_WIDTH  byte address, word aligned.
- rdata  out  DATA_WIDTH  registered read data.
- busy  out  1  engine running.
- irq  out  1  level interrupt = IRQ_EN & DONE, registered.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL RW: bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN.
  - 0x04 SRC_ADDR RW.
  - 0x08 DST_ADDR RW.
  - 0x0C LENGTH RW, bits[15:0], upper bits read 0.
  - 0x10 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bits[31:16] REMAINING (RO).
  - 0x14 XFER_CNT RO: count of completed transfers, wraps at 2^DATA_WIDTH.
- Unmapped or misaligned address (addr[1:0] != 0): write dropped, read returns 0; both set ERR.
- wr_en and rd_en together: write performed, read ignored (rdata holds), ERR set.
- Engine FSM, states IDLE, RUN, FINISH:
  - IDLE -> RUN on START with LENGTH != 0; REMAINING loads LENGTH.
  - START with LENGTH == 0: stays IDLE, ERR set.
  - RUN: REMAINING decrements by 1 per cycle; REMAINING == 1 -> FINISH.
  - FINISH: one cycle; REMAINING = 0, DONE set, XFER_CNT increments, -> IDLE.
- While BUSY (RUN or FINISH): START and writes to SRC_ADDR/DST_ADDR/LENGTH are ignored and set ERR. Writes to IRQ_EN and STATUS W1C remain accepted.
- busy = (state != IDLE).

## Timing
- Reset: all registers, rdata, busy, irq = 0; state IDLE. Reset mid-transfer aborts to IDLE with no DONE.
- Write takes effect at the sampling edge; a read of that register in the next cycle returns the new value.
- Read latency 1: rdata updates at the edge that samples rd_en and holds until the next read.
- A read issued in the same cycle as a write, or as an engine update, returns the pre-edge value.
- START sampled at edge N -> busy = 1 after edge N. LENGTH = L -> FINISH after edge N+L, DONE = 1 and busy = 0 after edge N+L+1. irq asserts one edge after DONE.
- W1C of DONE in the same cycle the engine sets DONE: set wins. W1C of ERR in the same cycle as a new error: set wins.
- DONE may be re-set by a later transfer without being cleared first.

## Structure
- Package dma_reg_pkg: register offsets, STATUS/CTRL bit positions, LENGTH width (16), engine state enum {IDLE, RUN, FINISH}.
- Sub-module dma_xfer_engine: FSM, REMAINING counter, done pulse, XFER_CNT. The top level keeps address decode, the register bank, W1C logic and the rdata register.

## Test plan
- Reset mid-RUN (LENGTH=10, rst at cycle 4): all outputs 0 next cycle; STATUS reads 0; XFER_CNT stays 0.
- Write SRC_ADDR=0xDEAD_BEEF, read it back: rdata = 0xDEAD_BEEF one edge after rd_en. Read CTRL after writing 0x3: returns 0x2.
- LENGTH=4, IRQ_EN=1, START: busy for 5 cycles; STATUS REMAINING steps 4,3,2,1,0; DONE=1; irq=1; XFER_CNT=1. Write STATUS 0x2: DONE and irq fall.
- START with LENGTH=0: busy stays 0, ERR=1. Write LENGTH while busy: value unchanged, ERR=1. Write STATUS 0x4: ERR=0.
- Read 0x40 and 0x02: rdata = 0, ERR=1. wr_en+rd_en together to LENGTH=7: LENGTH=7, rdata unchanged, ERR=1.
- DONE W1C in FINISH cycle: DONE reads 1. Back-to-back transfers of LENGTH=1 three times: XFER_CNT=3.

Source files
------------

// File: rtl/dma_reg_pkg.sv
// ============================================================================
// Module  : dma_reg_pkg
// Brief   : Register offsets, bit positions and engine state encoding shared
//           by the DMA register responder and its transfer engine.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package dma_reg_pkg;

    localparam int unsigned c_len_w       = 16;

    localparam int unsigned c_off_ctrl    = 32'h00;
    localparam int unsigned c_off_src     = 32'h04;
    localparam int unsigned c_off_dst     = 32'h08;
    localparam int unsigned c_off_len     = 32'h0C;
    localparam int unsigned c_off_status  = 32'h10;
    localparam int unsigned c_off_xfercnt = 32'h14;

    localparam int unsigned c_ctrl_start  = 0;
    localparam int unsigned c_ctrl_irq_en = 1;

    localparam int unsigned c_st_busy     = 0;
    localparam int unsigned c_st_done     = 1;
    localparam int unsigned c_st_err      = 2;
    localparam int unsigned c_st_rem_lsb  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } xfer_state_t;

endpackage

`default_nettype wire

// File: rtl/dma_xfer_engine.sv
// ============================================================================
// Module  : dma_xfer_engine
// Brief   : Countdown transfer engine: IDLE/RUN/FINISH FSM, remaining count,
//           one-cycle done pulse and completed-transfer counter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dma_xfer_engine
    import dma_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [c_len_w-1:0]    i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [c_len_w-1:0]    o_remaining,
    output logic [DATA_WIDTH-1:0] o_xfer_cnt
);

    localparam logic [c_len_w-1:0]    c_len_one = {{(c_len_w-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_cnt_one = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    xfer_state_t           r_state;
    xfer_state_t           w_state_nxt;
    logic [c_len_w-1:0]    r_rem;
    logic [c_len_w-1:0]    w_rem_nxt;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Start requests are ignored outside IDLE; the register bank flags those.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && (i_length != '0)) begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = i_length;
                end
            end
            RUN: begin
                w_rem_nxt = r_rem - c_len_one;
                if (r_rem == c_len_one) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_rem_nxt   = '0;
                w_cnt_nxt   = r_cnt + c_cnt_one;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    assign o_busy      = (r_state != IDLE);
    assign o_remaining = r_rem;
    assign o_xfer_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: rtl/dma_reg_responder.sv
// ============================================================================
// Module  : dma_reg_responder
// Brief   : DMA control-bus register responder: address decode, descriptor
//           registers, W1C status, registered read data and interrupt.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dma_reg_responder
    import dma_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] r_src;
    logic [DATA_WIDTH-1:0] r_dst;
    logic [c_len_w-1:0]    r_len;
    logic                  r_irq_en;
    logic                  r_done;
    logic                  r_err;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_busy;
    logic                  w_eng_done;
    logic [c_len_w-1:0]    w_rem;
    logic [DATA_WIDTH-1:0] w_xfer_cnt;

    logic w_aligned;
    logic w_hit_ctrl, w_hit_src, w_hit_dst, w_hit_len, w_hit_status, w_hit_xfercnt;
    logic w_mapped;
    logic w_start_req;
    logic w_err_set;
    logic w_done_clr;
    logic w_err_clr;
    logic w_desc_wr_ok;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_aligned     = (addr[1:0] == 2'b00);
    assign w_hit_ctrl    = w_aligned && (addr == ADDR_WIDTH'(c_off_ctrl));
    assign w_hit_src     = w_aligned && (addr == ADDR_WIDTH'(c_off_src));
    assign w_hit_dst     = w_aligned && (addr == ADDR_WIDTH'(c_off_dst));
    assign w_hit_len     = w_aligned && (addr == ADDR_WIDTH'(c_off_len));
    assign w_hit_status  = w_aligned && (addr == ADDR_WIDTH'(c_off_status));
    assign w_hit_xfercnt = w_aligned && (addr == ADDR_WIDTH'(c_off_xfercnt));
    assign w_mapped      = w_hit_ctrl | w_hit_src | w_hit_dst | w_hit_len
                         | w_hit_status | w_hit_xfercnt;

    assign w_start_req  = wr_en && w_hit_ctrl && wdata[c_ctrl_start];
    assign w_desc_wr_ok = wr_en && !w_busy;
    assign w_done_clr   = wr_en && w_hit_status && wdata[c_st_done];
    assign w_err_clr    = wr_en && w_hit_status && wdata[c_st_err];

    // Any of these raises ERR; a same-cycle W1C of ERR loses to the new error.
    assign w_err_set = ((wr_en || rd_en) && !w_mapped)
                     || (wr_en && rd_en)
                     || (w_start_req && (w_busy || (r_len == '0)))
                     || (wr_en && w_busy && (w_hit_src || w_hit_dst || w_hit_len));

    dma_xfer_engine #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_engine (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start_req),
        .i_length    (r_len),
        .o_busy      (w_busy),
        .o_done      (w_eng_done),
        .o_remaining (w_rem),
        .o_xfer_cnt  (w_xfer_cnt)
    );

    always_comb begin
        w_status               = '0;
        w_status[c_st_busy]    = w_busy;
        w_status[c_st_done]    = r_done;
        w_status[c_st_err]     = r_err;
        w_status[c_st_rem_lsb +: c_len_w] = w_rem;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_hit_ctrl) begin
            w_rd_data[c_ctrl_irq_en] = r_irq_en;
        end else if (w_hit_src) begin
            w_rd_data = r_src;
        end else if (w_hit_dst) begin
            w_rd_data = r_dst;
        end else if (w_hit_len) begin
            w_rd_data[c_len_w-1:0] = r_len;
        end else if (w_hit_status) begin
            w_rd_data = w_status;
        end else if (w_hit_xfercnt) begin
            w_rd_data = w_xfer_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_desc_wr_ok && w_hit_src) begin
                r_src <= wdata;
            end
            if (w_desc_wr_ok && w_hit_dst) begin
                r_dst <= wdata;
            end
            if (w_desc_wr_ok && w_hit_len) begin
                r_len <= wdata[c_len_w-1:0];
            end
            if (wr_en && w_hit_ctrl) begin
                r_irq_en <= wdata[c_ctrl_irq_en];
            end
            r_done <= w_eng_done || (r_done && !w_done_clr);
            r_err  <= w_err_set  || (r_err  && !w_err_clr);
            r_irq  <= r_irq_en && r_done;
            // A read colliding with a write is dropped and rdata holds.
            if (rd_en && !wr_en) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign rdata = r_rdata;
    assign busy  = w_busy;
    assign irq   = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_dma_reg_responder.sv
// ============================================================================
// Module  : tb_dma_reg_responder
// Brief   : Directed self-checking bench for the DMA register responder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_reg_responder;

    localparam logic [15:0] c_a_ctrl   = 16'h00;
    localparam logic [15:0] c_a_src    = 16'h04;
    localparam logic [15:0] c_a_dst    = 16'h08;
    localparam logic [15:0] c_a_len    = 16'h0C;
    localparam logic [15:0] c_a_status = 16'h10;
    localparam logic [15:0] c_a_cnt    = 16'h14;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [15:0] addr;
    logic [31:0] rdata;
    logic        busy;
    logic        irq;

    int total;
    int bad;

    dma_reg_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .busy  (busy),
        .irq   (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Bus helpers are entered at a negedge and return at the next negedge.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d     = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; addr = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({rdata, busy, irq} !== 34'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {rdata, busy, irq});
        end
        rst = 1'b0;
        @(negedge clk);
        do_write(c_a_src, 32'h0000_0055);
        do_read(c_a_src, v);
        total++;
        if (v !== 32'h55) begin bad++; $display("FAIL pre_reset_src: got %h want 00000055", v); end
        do_write(c_a_len, 32'd10);
        do_write(c_a_ctrl, 32'h1);
        idle(3);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        total++;
        if ({rdata, busy, irq} !== 34'd0) begin
            bad++; $display("FAIL reset_midrun_outputs: got %h want 0", {rdata, busy, irq});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 00000000", v); end
        idle(12);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_no_done: got %h want 00000000", v); end
        do_read(c_a_cnt, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_xfer_cnt: got %h want 00000000", v); end
        do_read(c_a_src, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_src: got %h want 00000000", v); end
        do_read(c_a_len, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_len: got %h want 00000000", v); end
    endtask

    task automatic test_rw();
        logic [31:0] v;
        do_write(c_a_src, 32'hDEAD_BEEF);
        do_read(c_a_src, v);
        total++;
        if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_src: got %h want deadbeef", v); end
        idle(2);
        total++;
        if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_hold: got %h want deadbeef", rdata); end
        do_write(c_a_dst, 32'h1234_5678);
        do_read(c_a_dst, v);
        total++;
        if (v !== 32'h1234_5678) begin bad++; $display("FAIL rw_dst: got %h want 12345678", v); end
        // LENGTH is still 0 here, so the START bit only raises ERR.
        do_write(c_a_ctrl, 32'h3);
        do_read(c_a_ctrl, v);
        total++;
        if (v !== 32'h2) begin bad++; $display("FAIL rw_ctrl: got %h want 00000002", v); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rw_len0_busy: got %b want 0", busy); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h4) begin bad++; $display("FAIL rw_len0_err: got %h want 00000004", v); end
        do_write(c_a_status, 32'h4);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL rw_err_clear: got %h want 00000000", v); end
        do_write(c_a_len, 32'h0001_0005);
        do_read(c_a_len, v);
        total++;
        if (v !== 32'h5) begin bad++; $display("FAIL rw_len_upper: got %h want 00000005", v); end
    endtask

    task automatic test_xfer();
        logic [31:0] v;
        logic [31:0] exp;
        do_write(c_a_len, 32'd4);
        do_write(c_a_ctrl, 32'h3);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL xfer_busy_start: got %b want 1", busy); end
        for (int k = 0; k < 5; k++) begin
            do_read(c_a_status, v);
            exp = ((32'd4 - k) << 16) | 32'h1;
            total++;
            if (v !== exp) begin bad++; $display("FAIL xfer_status_%0d: got %h want %h", k, v, exp); end
            total++;
            if (busy !== (k < 4)) begin bad++; $display("FAIL xfer_busy_%0d: got %b want %b", k, busy, (k < 4)); end
        end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h2) begin bad++; $display("FAIL xfer_done: got %h want 00000002", v); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL xfer_irq: got %b want 1", irq); end
        do_read(c_a_cnt, v);
        total++;
        if (v !== 32'd1) begin bad++; $display("FAIL xfer_cnt: got %h want 00000001", v); end
        do_write(c_a_status, 32'h2);
        idle(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL xfer_irq_clear: got %b want 0", irq); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL xfer_done_clear: got %h want 00000000", v); end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        do_write(c_a_len, 32'd0);
        do_write(c_a_ctrl, 32'h1);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL err_len0_busy: got %b want 0", busy); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h4) begin bad++; $display("FAIL err_len0_status: got %h want 00000004", v); end
        do_write(c_a_status, 32'h4);
        do_write(c_a_len, 32'd8);
        do_write(c_a_ctrl, 32'h1);
        do_write(c_a_len, 32'd3);
        do_read(c_a_len, v);
        total++;
        if (v !== 32'd8) begin bad++; $display("FAIL err_busy_len: got %h want 00000008", v); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0006_0005) begin bad++; $display("FAIL err_busy_status: got %h want 00060005", v); end
        idle(10);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL err_irq_gated: got %b want 0", irq); end
        do_write(c_a_status, 32'h6);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL err_w1c: got %h want 00000000", v); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        do_read(c_a_src, v);
        do_read(16'h0040, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL unmapped_rdata: got %h want 00000000", v); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h4) begin bad++; $display("FAIL unmapped_err: got %h want 00000004", v); end
        do_write(c_a_status, 32'h4);
        do_read(c_a_src, v);
        do_read(16'h0002, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL misaligned_rdata: got %h want 00000000", v); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h4) begin bad++; $display("FAIL misaligned_err: got %h want 00000004", v); end
        do_write(c_a_status, 32'h4);
    endtask

    task automatic test_simul();
        logic [31:0] v;
        do_read(c_a_src, v);
        addr  = c_a_len;
        wdata = 32'd7;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        total++;
        if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL simul_rdata_hold: got %h want deadbeef", rdata); end
        do_read(c_a_len, v);
        total++;
        if (v !== 32'd7) begin bad++; $display("FAIL simul_len: got %h want 00000007", v); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h4) begin bad++; $display("FAIL simul_err: got %h want 00000004", v); end
        do_write(c_a_status, 32'h4);
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        do_write(c_a_len, 32'd2);
        do_write(c_a_ctrl, 32'h1);
        idle(2);
        do_write(c_a_status, 32'h2);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h2) begin bad++; $display("FAIL race_done: got %h want 00000002", v); end
        addr  = c_a_status;
        wdata = 32'h4;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h6) begin bad++; $display("FAIL race_err: got %h want 00000006", v); end
        do_write(c_a_status, 32'h6);
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL race_clear: got %h want 00000000", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_write(c_a_len, 32'd1);
        for (int k = 0; k < 3; k++) begin
            do_write(c_a_ctrl, 32'h1);
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_%0d: got %b want 1", k, busy); end
            idle(2);
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_%0d: got %b want 0", k, busy); end
        end
        do_read(c_a_cnt, v);
        total++;
        if (v !== 32'd6) begin bad++; $display("FAIL b2b_cnt: got %h want 00000006", v); end
        do_read(c_a_status, v);
        total++;
        if (v !== 32'h2) begin bad++; $display("FAIL b2b_status: got %h want 00000002", v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_rw();
        test_xfer();
        test_errors();
        test_unmapped();
        test_simul();
        test_w1c_race();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
